// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// Latency: none, wires only.
// Backpressure: req is held until the one-cycle ack pulse.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Requester side: port 0 is the CPU load/store unit, port 1 is DMA/debug.
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [1:0]        size0;
    logic [1:0]        size1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic              ack0;
    logic              ack1;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;
    logic              err0;
    logic              err1;

    // Memory side.
    logic              MemWrite;
    logic [1:0]        MemRead;
    logic [31:0]       Address;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;

    // The arbiter itself.
    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        input  ReadData,
        output ack0, ack1, rdata0, rdata1, err0, err1,
        output MemWrite, MemRead, Address, WriteData
    );

    // Requesters plus the memory model.
    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        output ReadData,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
        input  MemWrite, MemRead, Address, WriteData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with sub-word load extraction and store read-modify-write.
// Latency req->ack: load 2, word store 2, sub-word store 3, illegal access 1 cycle.
// Backpressure: one access at a time; a waiting requester holds req until its ack pulse.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed port-0 priority.
module dmem_arbiter #(
    parameter int DEPTH_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        WR     = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        port_q, port_d;           // granted port
    logic [1:0]  size_q, size_d;
    logic [1:0]  offset_q, offset_d;       // byte lane within the word
    logic [15:0] sub_wdata_q, sub_wdata_d; // only the low half is needed for sub-word merges
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d; // full store word; doubles as the RMW merge register
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic        rr_q, rr_d;               // port that wins the next contention
`endif

    logic              grant;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_illegal;
    logic [4:0]        lane_shift;
    logic [31:0]       size_mask;
    logic [31:0]       rd_extract;
    logic [31:0]       rmw_merged;

    // Pick the winning port and mux its request fields.
    always_comb begin
        grant = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            grant = rr_q;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = bus.req1;
        end
        sel_we    = grant ? bus.we1    : bus.we0;
        sel_size  = grant ? bus.size1  : bus.size0;
        sel_addr  = grant ? bus.addr1  : bus.addr0;
        sel_wdata = grant ? bus.wdata1 : bus.wdata0;
        sel_illegal = (sel_size == 2'd0)
                   || (sel_size == 2'd2 && sel_addr[0])
                   || (sel_size == 2'd3 && sel_addr[1:0] != 2'b00)
                   || (sel_addr[ADDR_W-1:DEPTH_W+2] != '0);
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        lane_shift = {offset_q, 3'b000};
        case (size_q)
            2'd1:    size_mask = 32'h0000_00FF;
            2'd2:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        rd_extract = (bus.ReadData >> lane_shift) & size_mask;
        rmw_merged = (bus.ReadData & ~(size_mask << lane_shift))
                   | (({16'h0000, sub_wdata_q} & size_mask) << lane_shift);
    end

    // Next-state logic: arbitration and error check in IDLE, memory sequencing afterwards.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        size_d      = size_q;
        offset_d    = offset_q;
        sub_wdata_d = sub_wdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    port_d      = grant;
                    size_d      = sel_size;
                    offset_d    = sel_addr[1:0];
                    sub_wdata_d = sel_wdata[15:0];
                    err_d       = sel_illegal;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    if (bus.req0 && bus.req1) begin
                        rr_d = ~grant;
                    end
`endif
                    if (sel_illegal) begin
                        // No memory cycle for a bad access; Address/WriteData keep their old value.
                        state_d = DONE;
                    end else begin
                        mem_addr_d = {{(32-DEPTH_W){1'b0}}, sel_addr[DEPTH_W+1:2]};
                        if (!sel_we) begin
                            state_d = RD;
                        end else if (sel_size == 2'd3) begin
                            mem_wdata_d = sel_wdata;
                            state_d     = WR;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            RD: begin
                if (port_q) rdata1_d = rd_extract;
                else        rdata0_d = rd_extract;
                state_d = DONE;
            end
            RMW_RD: begin
                mem_wdata_d = rmw_merged;
                state_d     = RMW_WR;
            end
            RMW_WR:  state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            size_q      <= 2'd0;
            offset_q    <= 2'd0;
            sub_wdata_q <= 16'h0000;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            size_q      <= size_d;
            offset_q    <= offset_d;
            sub_wdata_q <= sub_wdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Strobes and acks decode straight from state so reset clears them at the edge.
    always_comb begin
        bus.MemWrite  = (state_q == RMW_WR) || (state_q == WR);
        bus.MemRead   = ((state_q == RD) || (state_q == RMW_RD)) ? 2'd3 : 2'd0;
        bus.Address   = mem_addr_q;
        bus.WriteData = mem_wdata_q;
        bus.ack0      = (state_q == DONE) && !port_q;
        bus.ack1      = (state_q == DONE) &&  port_q;
        bus.err0      = bus.ack0 && err_q;
        bus.err1      = bus.ack1 && err_q;
        bus.rdata0    = rdata0_q;
        bus.rdata1    = rdata1_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a 64-word memory model.
// Latency: expected ack cycles are computed from the request issue cycle.
// Backpressure: requests are held until ack, then dropped.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(.DEPTH_W(6), .ADDR_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the rising edge.
    logic [31:0] mem [64] = '{default: 32'h0};
    assign bus.ReadData = mem[bus.Address[5:0]];
    always @(posedge clk) begin
        if (bus.MemWrite === 1'b1) mem[bus.Address[5:0]] <= bus.WriteData;
    end

    typedef struct {
        bit          port;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } ack_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mop_t;

    ack_t ackq[$];
    mop_t mopq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ack(bit p, bit chk_rd, logic [31:0] rd, bit e, int at);
        ack_t a;
        a.port = p; a.chk_rd = chk_rd; a.rdata = rd; a.err = e; a.cyc = at;
        ackq.push_back(a);
    endfunction

    function automatic void push_mop(bit wr, logic [31:0] a, logic [31:0] d);
        mop_t m;
        m.wr = wr; m.addr = a; m.data = d;
        mopq.push_back(m);
    endfunction

    // Monitor: pops expectations whenever the DUT acks or cycles the memory.
    always @(negedge clk) begin
        ack_t e;
        mop_t m;
        if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
            if (ackq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack ack0=%b ack1=%b required none (cycle %0d)",
                         bus.ack0, bus.ack1, cyc);
            end else begin
                e = ackq.pop_front();
                chk("ack_port", {31'b0, bus.ack1}, {31'b0, e.port});
                chk("ack_onehot", {31'b0, bus.ack0 ^ bus.ack1}, 32'd1);
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_err", {31'b0, e.port ? bus.err1 : bus.err0}, {31'b0, e.err});
                if (e.chk_rd) chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.rdata);
            end
        end
        if (bus.MemWrite === 1'b1 || bus.MemRead != 2'd0) begin
            if (mopq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mem_cycle MemWrite=%b MemRead=%0d required idle (cycle %0d)",
                         bus.MemWrite, bus.MemRead, cyc);
            end else begin
                m = mopq.pop_front();
                chk("mem_kind_write", {31'b0, bus.MemWrite}, {31'b0, m.wr});
                chk("mem_read_code", {30'b0, bus.MemRead}, m.wr ? 32'd0 : 32'd3);
                chk("mem_address", bus.Address, m.addr);
                if (m.wr) chk("mem_wdata", bus.WriteData, m.data);
            end
        end
    end

    task automatic drive(input bit p, input bit r, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.req1 = r; bus.we1 = we; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = r; bus.we0 = we; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd;
        end
    endtask

    // Issue one access from an idle DUT, expect the ack lat cycles later, then drop req.
    task automatic issue(input bit p, input bit we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input bit chk_rd, input logic [31:0] exp_rd,
                         input bit exp_err, input int lat);
        bit got = 0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, sz, a, wd);
        push_ack(p, chk_rd, exp_rd, exp_err, cyc + lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin
                got = 1;
                break;
            end
        end
        drive(p, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout port=%0d actual=none required=ack", p);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"},   {30'b0, bus.ack1, bus.ack0}, 32'h0);
        chk({tag, "_err"},   {30'b0, bus.err1, bus.err0}, 32'h0);
        chk({tag, "_rdata0"}, bus.rdata0, 32'h0);
        chk({tag, "_rdata1"}, bus.rdata1, 32'h0);
        chk({tag, "_memctl"}, {29'b0, bus.MemWrite, bus.MemRead}, 32'h0);
        chk({tag, "_address"}, bus.Address, 32'h0);
        chk({tag, "_writedata"}, bus.WriteData, 32'h0);
    endtask

    initial begin
        int c0;
        int acks;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Word store then load on port 0.
        push_mop(1'b1, 32'd4, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 2'd3, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2);
        push_mop(1'b0, 32'd4, 32'h0);
        issue(1'b0, 1'b0, 2'd3, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);

        // Port 1 presets words 4 and 8.
        push_mop(1'b1, 32'd4, 32'h11223344);
        issue(1'b1, 1'b1, 2'd3, 32'h10, 32'h11223344, 1'b0, 32'h0, 1'b0, 2);
        push_mop(1'b1, 32'd8, 32'hCAFEF00D);
        issue(1'b1, 1'b1, 2'd3, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 2);

        // Byte RMW at 0x12 with junk in the upper store bits.
        push_mop(1'b0, 32'd4, 32'h0);
        push_mop(1'b1, 32'd4, 32'h11AA3344);
        issue(1'b0, 1'b1, 2'd1, 32'h12, 32'hFFFFFFAA, 1'b0, 32'h0, 1'b0, 3);

        // Sub-word loads.
        push_mop(1'b0, 32'd4, 32'h0);
        issue(1'b0, 1'b0, 2'd2, 32'h12, 32'h0, 1'b1, 32'h000011AA, 1'b0, 2);
        push_mop(1'b0, 32'd4, 32'h0);
        issue(1'b0, 1'b0, 2'd1, 32'h13, 32'h0, 1'b1, 32'h00000011, 1'b0, 2);

        // Halfword RMW on port 1 into the upper half of word 8, then read it back.
        push_mop(1'b0, 32'd8, 32'h0);
        push_mop(1'b1, 32'd8, 32'hBEEFF00D);
        issue(1'b1, 1'b1, 2'd2, 32'h22, 32'h1234BEEF, 1'b0, 32'h0, 1'b0, 3);
        push_mop(1'b0, 32'd8, 32'h0);
        issue(1'b1, 1'b0, 2'd3, 32'h20, 32'h0, 1'b1, 32'hBEEFF00D, 1'b0, 2);
        push_mop(1'b0, 32'd8, 32'h0);
        issue(1'b1, 1'b0, 2'd1, 32'h21, 32'h0, 1'b1, 32'h000000F0, 1'b0, 2);

        // Illegal accesses: no memory cycle, err with ack after 1 cycle, rdata held.
        issue(1'b0, 1'b0, 2'd2, 32'h11, 32'h0, 1'b1, 32'h00000011, 1'b1, 1);
        issue(1'b0, 1'b0, 2'd3, 32'h100, 32'h0, 1'b1, 32'h00000011, 1'b1, 1);
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b1, 32'h00000011, 1'b1, 1);
        issue(1'b1, 1'b1, 2'd3, 32'h22, 32'h55555555, 1'b1, 32'h000000F0, 1'b1, 1);
        chk("err_store_mem_untouched", mem[8], 32'hBEEFF00D);

        // Reset during RMW_RD of a byte store: no write, no ack.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 2'd1, 32'h12, 32'h00000055);
        push_mop(1'b0, 32'd4, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outputs_zero("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_mem_unchanged", mem[4], 32'h11AA3344);
        push_mop(1'b0, 32'd4, 32'h0);
        issue(1'b0, 1'b0, 2'd3, 32'h10, 32'h0, 1'b1, 32'h11AA3344, 1'b0, 2);

        // Contention: both ports hold word loads; acks every 3 cycles.
        @(posedge clk); #1;
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b0, 2'd3, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (k % 2 == 1) begin
                push_mop(1'b0, 32'd8, 32'h0);
                push_ack(1'b1, 1'b1, 32'hBEEFF00D, 1'b0, c0 + 2 + 3 * k);
            end else begin
                push_mop(1'b0, 32'd4, 32'h0);
                push_ack(1'b0, 1'b1, 32'h11AA3344, 1'b0, c0 + 2 + 3 * k);
            end
`else
            push_mop(1'b0, 32'd4, 32'h0);
            push_ack(1'b0, 1'b1, 32'h11AA3344, 1'b0, c0 + 2 + 3 * k);
`endif
        end
        acks = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) acks++;
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("contention_ack_count", acks, 32'd4);

        repeat (4) @(posedge clk);
        #1;
        chk("ackq_drained", ackq.size(), 32'd0);
        chk("mopq_drained", mopq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the 64-word data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Sequences each access into memory-side MemRead/MemWrite/Address/WriteData cycles.
- Performs byte/halfword extraction on reads and read-modify-write for byte/halfword stores, so the memory only ever sees full-word writes.
- Sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
- DEPTH_W, 6, word-index width into the data memory (64 words)
- ADDR_W, 32, requester byte-address width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- req0 / req1  in  1  access request, held high until ack
- we0 / we1  in  1  1 = store, 0 = load
- size0 / size1  in  2  1 = byte, 2 = halfword, 3 = word, 0 = illegal
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  32  store data, right-aligned
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  32  load data, zero-extended, valid while ack is high, held afterwards
- err0 / err1  out  1  pulses with ack on an illegal size, misaligned access, or out-of-range address
- MemWrite  out  1  memory write strobe
- MemRead  out  2  memory read-size code; this block drives only 0 or 3
- Address  out  32  word index {26'b0, addr[DEPTH_W+1:2]}
- WriteData  out  32  full word to memory
- ReadData  in  32  combinational memory read data

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State returns to IDLE.
  - All outputs go to 0: MemWrite, MemRead, Address, WriteData, ack*, rdata*, err*.
  - The priority pointer resets to port 0.
- States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
- IDLE arbitration:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port selected by the policy (see Optional Feature).
  - Latch the granted we/size/addr/wdata into internal registers.
- Error check in IDLE, applied before choosing the next state:
  - Illegal if size==0, or size==2 with addr[0]=1, or size==3 with addr[1:0]!=0, or addr[ADDR_W-1:DEPTH_W+2]!=0.
  - An illegal request goes straight to DONE with err set. No memory cycle is issued.
- Legal request, next state by type:
  - Load → RD.
  - Word store → WR.
  - Byte or halfword store → RMW_RD.
- RD:
  - Drive MemRead=3 and Address.
  - At the clock edge, capture ReadData shifted right by 8*addr[1:0] and masked to the access size (byte: [7:0], half: [15:0], word: all 32 bits).
  - Go to DONE.
- RMW_RD:
  - Drive MemRead=3.
  - Capture ReadData into the merge register.
  - Go to RMW_WR.
- RMW_WR:
  - Drive MemWrite=1.
  - WriteData = merge register with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Go to DONE.
- WR:
  - Drive MemWrite=1 with WriteData = wdata.
  - Go to DONE.
- DONE:
  - ack of the granted port is 1 for exactly one cycle.
  - rdata is updated only on loads; err as determined in IDLE.
  - Return to IDLE.
- Latency from req sampled in IDLE to ack:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Idle cycles:
  - MemWrite=0 and MemRead=0 outside the cycles listed above.
  - Address and WriteData hold their last value.
- Back-to-back requests:
  - A req held high after its ack is re-arbitrated in the following IDLE cycle.
  - Minimum spacing is one IDLE cycle between accesses.
- Requester-side rules:
  - Requesters must keep inputs stable until ack; the block latches them anyway, so later changes are ignored.
  - Deasserting req mid-transaction does not abort the transaction; ack is still issued.
- Reset mid-operation: the transaction is abandoned and no ack is issued.
  - If reset is asserted in RMW_RD, the memory is untouched because no write has occurred yet.
  - If reset is asserted in the RMW_WR/WR cycle, MemWrite is already asserted for that cycle; reset clears it at the edge.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration on contention. After a grant to port p, the pointer points to the other port.
  - On contention, the port the pointer indicates wins.
  - The pointer updates only on grants that occur with both reqs high.
- Undefined:
  - Fixed priority: port 0 always wins on contention.
  - The pointer register is not built.

Test Plan:
- Word store then load, port 0:
  - Stimulus: we0=1, size0=3, addr0=0x10, wdata0=0xDEADBEEF; then a load of the same address.
  - Response: MemWrite pulses one cycle with Address=4; the load ack comes 2 cycles after req with rdata0=0xDEADBEEF.
- Byte RMW:
  - Stimulus: word 4 preset to 0x11223344; store byte 0xAA at addr 0x12.
  - Response: RMW_RD then RMW_WR; WriteData=0x11AA3344; ack at cycle 3.
- Sub-word loads:
  - Stimulus: word 4 = 0x11AA3344; halfword load at 0x12, then byte load at 0x13.
  - Response: rdata = 0x000011AA, then 0x00000011.
- Errors:
  - Stimulus: halfword load at 0x11; separately, a word load at 0x100.
  - Response: err0=1 and ack0 pulse 1 cycle after req; MemRead and MemWrite stay 0.
- Contention:
  - Stimulus: req0 and req1 held high continuously with word loads.
  - Response: fixed priority grants port 0 every time; with DMEM_ARB_ROUND_ROBIN_EN the acks alternate 0,1,0,1.
- Reset mid-RMW:
  - Stimulus: reset_n=0 during RMW_RD of a byte store.
  - Response: no MemWrite pulse, no ack, memory word unchanged, all outputs 0 after the edge.
